// File: rtl/imem_loader_32.sv
// ============================================================================
// imem_loader_32 : word-addressed instruction memory with a byte-serial,
//                  big-endian program loader that holds the CPU while loading.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader_32 #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    output logic [31:0]       instruction,
    output logic              addr_err,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              cpu_hold
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   ptr_inc;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_clip;
    logic              accept;
    logic              word_wr;
    logic              last_word;
    logic              start_load;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] rd_idx;

    assign ptr_inc    = ptr + ONE;
    assign len_clip   = (ld_len > DEPTH_LEN) ? DEPTH_LEN : ld_len;
    assign start_load = (state == IDLE || state == RUN) && ld_start && (ld_len != '0);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        word_wr   = 1'b0;
        last_word = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (ld_start) begin
                    state_nxt = (ld_len == '0) ? RUN : LOAD;
                end
            end
            LOAD: begin
                accept    = ld_valid;
                word_wr   = ld_valid && (byte_cnt == 2'd3);
                last_word = word_wr && (ptr_inc == len);
                if (last_word) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            word_buf <= 24'd0;
            ptr      <= '0;
            len      <= '0;
            ld_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ld_done <= last_word;
            if (start_load) begin
                len      <= len_clip;
                ptr      <= '0;
                byte_cnt <= 2'd0;
            end else if (accept) begin
                // byte counter wraps to 0 on the 4th byte of each word
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= {word_buf[15:0], ld_byte};
                if (word_wr) begin
                    ptr <= ptr_inc;
                end
            end
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[ptr[ADDR_W-1:0]] <= {word_buf, ld_byte};
        end
    end

    assign rd_idx      = addr[ADDR_W+1:2];
    assign addr_err    = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
    assign cpu_hold    = (state != RUN);
    assign ld_ready    = (state == LOAD);
    assign instruction = (cpu_hold || addr_err) ? 32'd0 : mem[rd_idx];

endmodule

`default_nettype wire

// File: tb/tb_imem_loader_32.sv
// ============================================================================
// tb_imem_loader_32 : self-checking bench for imem_loader_32.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader_32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] instruction;
    logic        addr_err;
    logic        ld_start = 1'b0;
    logic [8:0]  ld_len = 9'd0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'd0;
    logic        ld_ready;
    logic        ld_done;
    logic        cpu_hold;

    imem_loader_32 #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .instruction (instruction),
        .addr_err    (addr_err),
        .ld_start    (ld_start),
        .ld_len      (ld_len),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .cpu_hold    (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } sb_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    sb_t         sb[$];
    logic [31:0] model [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a full load and records when ld_done pulses, relative to the start edge.
    task automatic run_load(input string nm, input logic [8:0] len, input logic [7:0] bytes[$],
                            input int stall_at, input int stall_n, input int exp_lat);
        int          cyc = 0;
        int          done_at = -1;
        int          pulses = 0;
        int          hold_bad = 0;
        logic [31:0] w = 32'd0;
        addr     = 32'd0;
        ld_start = 1'b1;
        ld_len   = len;
        tick();
        ld_start = 1'b0;
        chk({nm, "_ready_after_start"}, {31'd0, ld_ready}, 32'd1);
        chk({nm, "_hold_after_start"}, {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < bytes.size(); i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    if (!cpu_hold || !ld_ready || instruction !== 32'd0) hold_bad++;
                    ld_valid = 1'b0;
                    tick();
                    cyc++;
                    if (ld_done) begin pulses++; if (done_at < 0) done_at = cyc; end
                end
            end
            if (!cpu_hold || !ld_ready || instruction !== 32'd0) hold_bad++;
            ld_valid = 1'b1;
            ld_byte  = bytes[i];
            w = {w[23:0], bytes[i]};
            if (i % 4 == 3) begin
                sb.push_back({32'((i / 4) * 4), w});
                model[i / 4] = w;
            end
            tick();
            cyc++;
            if (ld_done) begin pulses++; if (done_at < 0) done_at = cyc; end
        end
        ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            cyc++;
            if (ld_done) begin pulses++; if (done_at < 0) done_at = cyc; end
        end
        chk({nm, "_hold_during_load"}, 32'(hold_bad), 32'd0);
        chk({nm, "_done_latency"}, 32'(done_at), 32'(exp_lat));
        chk({nm, "_done_pulses"}, 32'(pulses), 32'd1);
        chk({nm, "_hold_after"}, {31'd0, cpu_hold}, 32'd0);
        chk({nm, "_ready_after"}, {31'd0, ld_ready}, 32'd0);
    endtask

    task automatic drain_sb(input string nm);
        sb_t e;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            addr = e.a;
            #1;
            chk($sformatf("%s_word@%h", nm, e.a), instruction, e.d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] two_word[$];
        logic [7:0] partial[$];
        logic [7:0] full[$];
        logic [7:0] reload[$];
        logic [7:0] kb;
        vec_t       tbl[7];
        logic [31:0] old1;

        two_word = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h10, 8'h00};
        partial  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        reload   = '{8'hAC, 8'h01, 8'h00, 8'h04};
        for (int k = 0; k < 256; k++) begin
            kb = k[7:0];
            full.push_back(8'hA5);
            full.push_back(kb);
            full.push_back(~kb);
            full.push_back(8'h3C);
        end

        // Reset, then idle read
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        addr  = 32'd0;
        #1;
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
        tick();

        // Two-word load from IDLE
        run_load("two", 9'd2, two_word, -1, 0, 8);
        drain_sb("two");

        // Reset after 6 of 8 bytes: word 0 written, word 1 untouched
        ld_start = 1'b1;
        ld_len   = 9'd2;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1;
            ld_byte  = partial[i];
            tick();
        end
        ld_valid = 1'b0;
        model[0] = 32'h11223344;
        reset = 1'b1;
        #1;
        chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        ld_start = 1'b1;
        ld_len   = 9'd0;
        tick();
        ld_start = 1'b0;
        chk("midrst_run_hold", {31'd0, cpu_hold}, 32'd0);
        addr = 32'h0;
        #1;
        chk("midrst_word0", instruction, model[0]);
        addr = 32'h4;
        #1;
        chk("midrst_word1_kept", instruction, model[1]);

        // Stalled stream, started from RUN
        run_load("stall", 9'd2, two_word, 2, 3, 11);
        drain_sb("stall");

        // Over-long length is clipped to DEPTH; pointer must not wrap
        run_load("full", 9'h1FF, full, -1, 0, 1024);
        drain_sb("full");

        // Read-path table
        tbl[0] = '{32'h0000_0000, model[0],   1'b0};
        tbl[1] = '{32'h0000_0006, 32'd0,      1'b1};
        tbl[2] = '{32'h0000_0400, 32'd0,      1'b1};
        tbl[3] = '{32'h0000_03FC, model[255], 1'b0};
        tbl[4] = '{32'h0000_03FD, 32'd0,      1'b1};
        tbl[5] = '{32'h8000_0000, 32'd0,      1'b1};
        tbl[6] = '{32'h0000_0200, model[128], 1'b0};
        for (int i = 0; i < 7; i++) begin
            addr = tbl[i].a;
            #1;
            chk($sformatf("tbl%0d_instr", i), instruction, tbl[i].exp_instr);
            chk($sformatf("tbl%0d_err", i), {31'd0, addr_err}, {31'd0, tbl[i].exp_err});
        end

        // Reload one word from RUN; word 1 keeps its previous contents
        old1 = model[1];
        run_load("reload", 9'd1, reload, -1, 0, 4);
        drain_sb("reload");
        addr = 32'h4;
        #1;
        chk("reload_word1_kept", instruction, old1);
        chk("reload_word0_const", model[0], 32'hAC010004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
